// File: rtl/cv32e40p_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_recovery_ctrl
// Description : Sequences a CV32E40P rollback. It holds the core in setback,
//               copies the backup register file into the core RF two
//               registers per cycle, restores the PC, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_recovery_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        recovery_req_i,
    input  logic        core_idle_i,
    output logic        setback_o,
    output logic        recover_o,
    output logic        pc_recover_o,
    output logic [5:0]  bkp_raddr_a_o,
    output logic [5:0]  bkp_raddr_b_o,
    input  logic [31:0] bkp_rdata_a_i,
    input  logic [31:0] bkp_rdata_b_i,
    output logic        regfile_we_a_o,
    output logic [5:0]  regfile_waddr_a_o,
    output logic [31:0] regfile_wdata_a_o,
    output logic        regfile_we_b_o,
    output logic [5:0]  regfile_waddr_b_o,
    output logic [31:0] regfile_wdata_b_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o
);

    localparam int c_num_pairs = NUM_REGS / 2;
    localparam int c_pair_w    = $clog2(c_num_pairs);
    localparam int c_sb_w      = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [c_pair_w-1:0] c_last_pair = c_pair_w'(c_num_pairs - 1);
    localparam logic [c_sb_w-1:0]   c_sb_last   = c_sb_w'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SETBACK    = 3'd1,
        S_RF_RESTORE = 3'd2,
        S_RF_DRAIN   = 3'd3,
        S_CSR_PC     = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_sb_w-1:0]   r_sb_cnt;
    logic [c_pair_w-1:0] r_pair;
    logic                r_rd_vld;
    logic                r_wr_pend;
    logic                r_setback;
    logic                r_recover;
    logic                r_pc_recover;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic [5:0]          r_raddr_a;
    logic [5:0]          r_raddr_b;
    logic                r_we_a;
    logic                r_we_b;
    logic [5:0]          r_waddr_a;
    logic [5:0]          r_waddr_b;

    logic [4:0]          w_pair_next;
    logic                w_sb_exit_idle;
    logic                w_sb_exit_tmo;

    assign w_pair_next    = 5'(r_pair) + 5'd1;
    // r_sb_cnt counts completed SETBACK cycles minus one, so a non-zero value
    // means the state has already lasted at least two cycles at this edge.
    assign w_sb_exit_idle = (r_sb_cnt != '0) && core_idle_i;
    assign w_sb_exit_tmo  = (r_sb_cnt == c_sb_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_sb_cnt     <= '0;
            r_pair       <= '0;
            r_rd_vld     <= 1'b0;
            r_wr_pend    <= 1'b0;
            r_setback    <= 1'b0;
            r_recover    <= 1'b0;
            r_pc_recover <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_raddr_a    <= 6'd0;
            r_raddr_b    <= 6'd0;
            r_we_a       <= 1'b0;
            r_we_b       <= 1'b0;
            r_waddr_a    <= 6'd0;
            r_waddr_b    <= 6'd0;
        end else begin
            // Write stage trails the read stage by one cycle to meet the
            // backup memory read latency; x0 is never written.
            r_wr_pend    <= r_rd_vld;
            r_we_a       <= r_rd_vld && (r_raddr_a != 6'd0);
            r_we_b       <= r_rd_vld;
            r_waddr_a    <= r_rd_vld ? r_raddr_a : 6'd0;
            r_waddr_b    <= r_rd_vld ? r_raddr_b : 6'd0;
            r_rd_vld     <= 1'b0;
            r_done       <= 1'b0;
            r_pc_recover <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (recovery_req_i) begin
                        r_state   <= S_SETBACK;
                        r_sb_cnt  <= '0;
                        r_setback <= 1'b1;
                        r_busy    <= 1'b1;
                        r_timeout <= 1'b0;
                    end
                end
                S_SETBACK: begin
                    if (w_sb_exit_idle || w_sb_exit_tmo) begin
                        r_state   <= S_RF_RESTORE;
                        r_pair    <= '0;
                        r_raddr_a <= 6'd0;
                        r_raddr_b <= 6'd1;
                        r_rd_vld  <= 1'b1;
                        r_recover <= 1'b1;
                        if (!w_sb_exit_idle) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_sb_cnt <= r_sb_cnt + c_sb_w'(1);
                    end
                end
                S_RF_RESTORE: begin
                    if (r_pair == c_last_pair) begin
                        r_state   <= S_RF_DRAIN;
                        r_raddr_a <= 6'd0;
                        r_raddr_b <= 6'd0;
                    end else begin
                        r_pair    <= r_pair + c_pair_w'(1);
                        r_raddr_a <= {w_pair_next, 1'b0};
                        r_raddr_b <= {w_pair_next, 1'b1};
                        r_rd_vld  <= 1'b1;
                    end
                end
                S_RF_DRAIN: begin
                    r_state      <= S_CSR_PC;
                    r_recover    <= 1'b0;
                    r_pc_recover <= 1'b1;
                end
                S_CSR_PC: begin
                    r_state   <= S_DONE;
                    r_setback <= 1'b0;
                    r_done    <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_setback <= 1'b0;
                    r_recover <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign setback_o         = r_setback;
    assign recover_o         = r_recover;
    assign pc_recover_o      = r_pc_recover;
    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign timeout_o         = r_timeout;
    assign bkp_raddr_a_o     = r_raddr_a;
    assign bkp_raddr_b_o     = r_raddr_b;
    assign regfile_we_a_o    = r_we_a;
    assign regfile_we_b_o    = r_we_b;
    assign regfile_waddr_a_o = r_waddr_a;
    assign regfile_waddr_b_o = r_waddr_b;
    // Backup data arrives combinationally in the write cycle; gated so the
    // write data bus reads zero whenever no write is pending (incl. reset).
    assign regfile_wdata_a_o = r_wr_pend ? bkp_rdata_a_i : 32'd0;
    assign regfile_wdata_b_o = r_wr_pend ? bkp_rdata_b_i : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_recovery_ctrl
// Description : Bench for cv32e40p_recovery_ctrl with three instances
//               (32 regs, 64 regs, 32 regs with IDLE_TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_recovery_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic req;
    logic core_idle;

    logic        setback [3];
    logic        recover [3];
    logic        pc_rec  [3];
    logic        we_a    [3];
    logic        we_b    [3];
    logic        busy    [3];
    logic        done    [3];
    logic        tmo     [3];
    logic [5:0]  raddr_a [3];
    logic [5:0]  raddr_b [3];
    logic [5:0]  waddr_a [3];
    logic [5:0]  waddr_b [3];
    logic [31:0] rdata_a [3];
    logic [31:0] rdata_b [3];
    logic [31:0] wdata_a [3];
    logic [31:0] wdata_b [3];

    int n_checks = 0;
    int n_err    = 0;

    function automatic int np(input int i);
        return (i == 1) ? 32 : 16;
    endfunction

    function automatic int tmo_of(input int i);
        return (i == 2) ? 8 : 255;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            cv32e40p_recovery_ctrl #(
                .NUM_REGS    ((gi == 1) ? 64 : 32),
                .IDLE_TIMEOUT((gi == 2) ? 8 : 255)
            ) u_dut (
                .clk_i            (clk),
                .rst_i            (rst),
                .recovery_req_i   (req),
                .core_idle_i      (core_idle),
                .setback_o        (setback[gi]),
                .recover_o        (recover[gi]),
                .pc_recover_o     (pc_rec[gi]),
                .bkp_raddr_a_o    (raddr_a[gi]),
                .bkp_raddr_b_o    (raddr_b[gi]),
                .bkp_rdata_a_i    (rdata_a[gi]),
                .bkp_rdata_b_i    (rdata_b[gi]),
                .regfile_we_a_o   (we_a[gi]),
                .regfile_waddr_a_o(waddr_a[gi]),
                .regfile_wdata_a_o(wdata_a[gi]),
                .regfile_we_b_o   (we_b[gi]),
                .regfile_waddr_b_o(waddr_b[gi]),
                .regfile_wdata_b_o(wdata_b[gi]),
                .busy_o           (busy[gi]),
                .done_o           (done[gi]),
                .timeout_o        (tmo[gi])
            );
        end
    endgenerate

    initial begin
        forever #5 clk = ~clk;
    end

    // Backup memory: content is 0xA000_0000 + address, one-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rdata_a[i] <= 32'hA000_0000 + 32'(raddr_a[i]);
            rdata_b[i] <= 32'hA000_0000 + 32'(raddr_b[i]);
        end
    end

    // Timeline model: a sequence is the cycle index t since acceptance plus
    // the SETBACK length L once known; every output follows from (t, L).
    bit m_active [3];
    int m_t      [3];
    int m_L      [3];
    bit m_tmo    [3];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_active[i] <= 1'b0;
                m_t[i]      <= 0;
                m_L[i]      <= -1;
                m_tmo[i]    <= 1'b0;
            end else if (!m_active[i]) begin
                if (req) begin
                    m_active[i] <= 1'b1;
                    m_t[i]      <= 0;
                    m_L[i]      <= -1;
                    m_tmo[i]    <= 1'b0;
                end
            end else if (m_L[i] < 0) begin
                if (m_t[i] + 1 >= 2 && core_idle) begin
                    m_L[i] <= m_t[i] + 1;
                end else if (m_t[i] + 1 == tmo_of(i)) begin
                    m_L[i]   <= m_t[i] + 1;
                    m_tmo[i] <= 1'b1;
                end
                m_t[i] <= m_t[i] + 1;
            end else if (m_t[i] == m_L[i] + np(i) + 2) begin
                m_active[i] <= 1'b0;
            end else begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", nm, i, $time, act, exp);
        end
    endtask

    initial begin : p_cmp
        int t, L, n, j;
        bit act, e_sb, e_rec, e_pc, e_done, e_wa, e_wb;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                act    = m_active[i];
                t      = m_t[i];
                L      = m_L[i];
                n      = np(i);
                j      = t - L - 1;
                e_sb   = act && ((L < 0) || (t < L + n + 2));
                e_rec  = act && (L >= 0) && (t >= L) && (t <= L + n);
                e_pc   = act && (L >= 0) && (t == L + n + 1);
                e_done = act && (L >= 0) && (t == L + n + 2);
                e_wb   = act && (L >= 0) && (j >= 0) && (j < n);
                e_wa   = e_wb && (j != 0);
                chk("busy_o", i, 32'(busy[i]), 32'(act));
                chk("setback_o", i, 32'(setback[i]), 32'(e_sb));
                chk("recover_o", i, 32'(recover[i]), 32'(e_rec));
                chk("pc_recover_o", i, 32'(pc_rec[i]), 32'(e_pc));
                chk("done_o", i, 32'(done[i]), 32'(e_done));
                chk("timeout_o", i, 32'(tmo[i]), 32'(m_tmo[i]));
                chk("we_a", i, 32'(we_a[i]), 32'(e_wa));
                chk("we_b", i, 32'(we_b[i]), 32'(e_wb));
                if (e_rec && (t - L < n)) begin
                    chk("raddr_a", i, 32'(raddr_a[i]), 32'(2 * (t - L)));
                    chk("raddr_b", i, 32'(raddr_b[i]), 32'(2 * (t - L) + 1));
                end
                if (e_wb) begin
                    chk("waddr_b", i, 32'(waddr_b[i]), 32'(2 * j + 1));
                    chk("wdata_b", i, wdata_b[i], 32'hA000_0000 + 32'(2 * j + 1));
                end
                if (e_wa) begin
                    chk("waddr_a", i, 32'(waddr_a[i]), 32'(2 * j));
                    chk("wdata_a", i, wdata_a[i], 32'hA000_0000 + 32'(2 * j));
                end
            end
        end
    end

    int st_busy [3], st_wa [3], st_wa0 [3], st_wb [3], st_done [3], st_pcd [3], st_sb [3];
    bit seen_rec [3], prev_pc [3];

    initial begin : p_stats
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (busy[i]) st_busy[i]++;
                if (we_a[i]) st_wa[i]++;
                if (we_a[i] && waddr_a[i] == 6'd0) st_wa0[i]++;
                if (we_b[i]) st_wb[i]++;
                if (done[i]) st_done[i]++;
                if (done[i] && prev_pc[i]) st_pcd[i]++;
                if (recover[i]) seen_rec[i] = 1'b1;
                if (setback[i] && !recover[i] && !seen_rec[i]) st_sb[i]++;
                prev_pc[i] = pc_rec[i];
            end
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin
            st_busy[i] = 0; st_wa[i] = 0; st_wa0[i] = 0; st_wb[i] = 0;
            st_done[i] = 0; st_pcd[i] = 0; st_sb[i] = 0;
            seen_rec[i] = 1'b0; prev_pc[i] = 1'b0;
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((m_active[0] || m_active[1] || m_active[2]) && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c >= budget) begin
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, required under %0d", c, budget);
        end
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("busy_after_seq", i, 32'(busy[i]), 32'd0);
    endtask

    task automatic chk_zero();
        for (int i = 0; i < 3; i++) begin
            chk("rst_setback", i, 32'(setback[i]), 32'd0);
            chk("rst_recover", i, 32'(recover[i]), 32'd0);
            chk("rst_pc", i, 32'(pc_rec[i]), 32'd0);
            chk("rst_busy", i, 32'(busy[i]), 32'd0);
            chk("rst_done", i, 32'(done[i]), 32'd0);
            chk("rst_timeout", i, 32'(tmo[i]), 32'd0);
            chk("rst_we", i, {30'd0, we_a[i], we_b[i]}, 32'd0);
            chk("rst_raddr", i, {20'd0, raddr_a[i], raddr_b[i]}, 32'd0);
            chk("rst_waddr", i, {20'd0, waddr_a[i], waddr_b[i]}, 32'd0);
            chk("rst_wdata_a", i, wdata_a[i], 32'd0);
            chk("rst_wdata_b", i, wdata_b[i], 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req       = 1'b0;
        core_idle = 1'b1;
        clear_stats();
        repeat (3) @(negedge clk);
        #1;
        chk_zero();
        #1 rst = 1'b0;

        // Nominal restore with core already idle.
        repeat (2) @(negedge clk);
        clear_stats();
        pulse_req();
        wait_idle(200);
        chk("nom_busy_cycles", 0, 32'(st_busy[0]), 32'd21);
        chk("nom_busy_cycles", 1, 32'(st_busy[1]), 32'd37);
        chk("nom_busy_cycles", 2, 32'(st_busy[2]), 32'd21);
        chk("nom_writes_b", 0, 32'(st_wb[0]), 32'd16);
        chk("nom_writes_b", 1, 32'(st_wb[1]), 32'd32);
        chk("nom_writes_a", 0, 32'(st_wa[0]), 32'd15);
        chk("nom_writes_a", 1, 32'(st_wa[1]), 32'd31);
        for (int i = 0; i < 3; i++) begin
            chk("nom_x0_writes", i, 32'(st_wa0[i]), 32'd0);
            chk("nom_done_pulses", i, 32'(st_done[i]), 32'd1);
            chk("nom_pc_before_done", i, 32'(st_pcd[i]), 32'd1);
            chk("nom_setback_len", i, 32'(st_sb[i]), 32'd2);
            chk("nom_timeout", i, 32'(tmo[i]), 32'd0);
        end

        // Core becomes idle on the 10th SETBACK edge; the TIMEOUT=8 copy expires first.
        clear_stats();
        @(negedge clk);
        req       = 1'b1;
        core_idle = 1'b0;
        @(negedge clk);
        req = 1'b0;
        repeat (9) @(negedge clk);
        core_idle = 1'b1;
        wait_idle(200);
        chk("wait_setback_len", 0, 32'(st_sb[0]), 32'd10);
        chk("wait_setback_len", 1, 32'(st_sb[1]), 32'd10);
        chk("wait_setback_len", 2, 32'(st_sb[2]), 32'd8);
        chk("wait_busy_cycles", 0, 32'(st_busy[0]), 32'd29);
        chk("wait_timeout", 0, 32'(tmo[0]), 32'd0);
        chk("wait_timeout", 1, 32'(tmo[1]), 32'd0);
        chk("wait_timeout", 2, 32'(tmo[2]), 32'd1);

        // Core never idle: every instance times out.
        clear_stats();
        @(negedge clk);
        req       = 1'b1;
        core_idle = 1'b0;
        @(negedge clk);
        req = 1'b0;
        wait_idle(400);
        chk("tmo_setback_len", 0, 32'(st_sb[0]), 32'd255);
        chk("tmo_setback_len", 1, 32'(st_sb[1]), 32'd255);
        chk("tmo_setback_len", 2, 32'(st_sb[2]), 32'd8);
        core_idle = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("tmo_sticky", i, 32'(tmo[i]), 32'd1);

        // Next request clears timeout; a second request during restore is ignored.
        clear_stats();
        pulse_req();
        for (int i = 0; i < 3; i++) chk("tmo_cleared", i, 32'(tmo[i]), 32'd0);
        repeat (4) @(negedge clk);
        pulse_req();
        wait_idle(200);
        for (int i = 0; i < 3; i++) chk("busy_req_done_pulses", i, 32'(st_done[i]), 32'd1);

        // Reset in the k=5 cycle, then restart with the request held high.
        pulse_req();
        repeat (7) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("k5_raddr_a", i, 32'(raddr_a[i]), 32'd10);
            chk("k5_raddr_b", i, 32'(raddr_b[i]), 32'd11);
        end
        #2;
        rst = 1'b1;
        req = 1'b1;
        #1;
        chk_zero();
        clear_stats();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        req = 1'b0;
        wait_idle(200);
        chk("restart_writes_b", 0, 32'(st_wb[0]), 32'd16);
        chk("restart_writes_b", 1, 32'(st_wb[1]), 32'd32);
        chk("restart_busy_cycles", 1, 32'(st_busy[1]), 32'd37);
        for (int i = 0; i < 3; i++) chk("restart_done_pulses", i, 32'(st_done[i]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cv32e40p_recovery_ctrl.md
CV32E40P_RECOVERY_CTRL -- requirements
Module: cv32e40p_recovery_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, giving the number of registers restored; legal values are 32 and 64, where 64 includes FP registers.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 255, giving the maximum number of cycles to wait for core_idle_i.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port recovery_req_i, input, 1 bit: recovery request, level-sensitive, sampled only in IDLE.
REQ-006 SHALL have port core_idle_i, input, 1 bit: core has no outstanding bus transactions.
REQ-007 SHALL have port setback_o, output, 1 bit: drives the core setback input.
REQ-008 SHALL have port recover_o, output, 1 bit: drives the core recover_i (RF recovery-port enable).
REQ-009 SHALL have port pc_recover_o, output, 1 bit: drives the core pc_recover_i.
REQ-010 SHALL have ports bkp_raddr_a_o and bkp_raddr_b_o, output, 6 bits each: backup-source read addresses.
REQ-011 SHALL have ports bkp_rdata_a_i and bkp_rdata_b_i, input, 32 bits each: backup read data, valid exactly 1 cycle after the address.
REQ-012 SHALL have ports regfile_we_a_o, regfile_waddr_a_o and regfile_wdata_a_o, output, 1/6/32 bits: core RF write port A.
REQ-013 SHALL have ports regfile_we_b_o, regfile_waddr_b_o and regfile_wdata_b_o, output, 1/6/32 bits: core RF write port B.
REQ-014 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done_o, output, 1 bit: 1-cycle completion pulse.
REQ-016 SHALL have port timeout_o, output, 1 bit: sticky flag set when the idle wait expires.

Function
REQ-017 SHALL implement the FSM states IDLE, SETBACK, RF_RESTORE, RF_DRAIN, CSR_PC and DONE.
REQ-018 SHALL move IDLE->SETBACK on the first clock edge at which recovery_req_i=1.
REQ-019 SHALL clear timeout_o on the IDLE->SETBACK transition.
REQ-020 SHALL hold setback_o=1 in SETBACK, RF_RESTORE, RF_DRAIN and CSR_PC, and 0 in IDLE and DONE.
REQ-021 SHALL leave SETBACK for RF_RESTORE once the state has lasted at least 2 cycles and core_idle_i=1.
REQ-022 SHALL also leave SETBACK for RF_RESTORE, and set timeout_o=1, after IDLE_TIMEOUT cycles in SETBACK without core_idle_i; timeout_o then holds until the next request is accepted.
REQ-023 SHALL, in RF_RESTORE, use a counter k from 0 to NUM_REGS/2-1 and drive bkp_raddr_a_o=2k and bkp_raddr_b_o=2k+1, one pair per cycle.
REQ-024 SHALL, one cycle after each read, assert regfile_we_a_o and regfile_we_b_o with the registered addresses and with bkp_rdata_a_i and bkp_rdata_b_i as the write data.
REQ-025 SHALL move RF_RESTORE->RF_DRAIN after k=NUM_REGS/2-1; RF_DRAIN issues the final write pair and lasts 1 cycle.
REQ-026 SHALL keep regfile_we_a_o=0 for address 0, since x0 is never written; its address and data values are don't-care.
REQ-027 SHALL hold recover_o=1 exactly in RF_RESTORE and RF_DRAIN.
REQ-028 SHALL hold write enables at 0 in every cycle that has no pending write.
REQ-029 SHALL make CSR_PC last 1 cycle with pc_recover_o=1, then go to DONE.
REQ-030 SHALL make DONE last 1 cycle with done_o=1 and busy_o=1, then go to IDLE.
REQ-031 SHALL ignore recovery_req_i in every non-IDLE state; a request held high through DONE starts a new sequence from IDLE on the next edge.
REQ-032 SHALL, for NUM_REGS=32 with core_idle_i=1, take 21 cycles from request acceptance to done_o: SETBACK 2, RF_RESTORE 16, RF_DRAIN 1, CSR_PC 1, DONE 1.
REQ-033 SHALL use counter widths that do not wrap before their terminal counts at maximum parameter values.

Reset
REQ-034 SHALL, while rst_i=1, put the FSM in IDLE immediately (asynchronously), including mid-sequence.
REQ-035 SHALL, while rst_i=1, drive every output to 0: setback_o, recover_o, pc_recover_o, all write enables, all addresses and write data, busy_o, done_o and timeout_o.
REQ-036 SHALL clear all counters and pipeline registers on reset.
REQ-037 SHALL accept a request on the first edge after rst_i falls if recovery_req_i=1.

Verification
REQ-038 SHALL cover the nominal case: NUM_REGS=32, core_idle_i=1, 1-cycle recovery_req_i pulse, backup data = 0xA000_0000+addr -> writes 1..31 with matching data, no write to 0, done_o exactly 21 cycles after acceptance, pc_recover_o high 1 cycle before done_o.
REQ-039 SHALL cover the idle wait: core_idle_i low for 10 cycles after request -> SETBACK lasts 10 cycles, RF_RESTORE follows, timeout_o=0.
REQ-040 SHALL cover the timeout: IDLE_TIMEOUT=8, core_idle_i never high -> RF_RESTORE entered after 8 SETBACK cycles, timeout_o=1 sticky, cleared at the next accepted request.
REQ-041 SHALL cover a request during busy: recovery_req_i pulsed in RF_RESTORE -> no effect, exactly one done_o.
REQ-042 SHALL cover reset mid-sequence: rst_i asserted at k=5 -> all outputs 0 in the same cycle; after release with recovery_req_i=1 the restore restarts from address pair 0/1.
REQ-043 SHALL cover NUM_REGS=64: 32 write pairs covering addresses 0..63, done_o 37 cycles after acceptance.
